// File: rtl/fetch_btb_stage_if.sv
// Fetch-stage bus: execute-stage redirect/update inputs, instruction memory
// port, and the prediction/IF-ID outputs of the fetch stage.
interface fetch_btb_stage_if;
    logic        i_pc_enable;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_data;
    logic [31:0] o_pc_cur;
    logic [31:0] o_pc_four;
    logic [31:0] o_instruct;
    logic        o_prediction;
    logic [31:0] o_pred_target;

    modport master (
        output i_pc_enable, i_redirect, i_redirect_pc,
        output i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target,
        output i_imem_data,
        input  o_imem_addr, o_pc_cur, o_pc_four, o_instruct,
        input  o_prediction, o_pred_target
    );

    modport slave (
        input  i_pc_enable, i_redirect, i_redirect_pc,
        input  i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target,
        input  i_imem_data,
        output o_imem_addr, o_pc_cur, o_pc_four, o_instruct,
        output o_prediction, o_pred_target
    );
endinterface

// File: rtl/fetch_btb_stage.sv
// Instruction-fetch stage: PC register plus a direct-mapped BTB with 2-bit
// saturating direction counters; predicts the next PC every cycle.
module fetch_btb_stage #(
    parameter int          BTB_DEPTH = 16,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [1:0]  CNT_INIT  = 2'b01
) (
    input logic              i_clk,
    input logic              i_rst,
    fetch_btb_stage_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]      pc_q;
    logic             btb_valid  [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
    logic [29:0]      btb_target [BTB_DEPTH];
    logic [1:0]       btb_cnt    [BTB_DEPTH];

    // Lookup side, purely from the PC register.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             prediction;
    logic [31:0]      pc_four;
    logic [31:0]      pred_target;

    assign lk_idx      = pc_q[IDX_W+1:2];
    assign lk_tag      = pc_q[31:IDX_W+2];
    assign lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign prediction  = lk_hit && btb_cnt[lk_idx][1];
    assign pc_four     = pc_q + 32'd4;
    assign pred_target = prediction ? {btb_target[lk_idx], 2'b00} : pc_four;

    // Update side: word addresses drop the byte-offset bits up front.
    logic [29:0]      upd_word;
    logic [29:0]      upd_tgt_word;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       cnt_next;

    assign upd_word     = 30'(bus.i_upd_pc >> 2);
    assign upd_tgt_word = 30'(bus.i_upd_target >> 2);
    assign up_idx       = upd_word[IDX_W-1:0];
    assign up_tag       = upd_word[29:IDX_W];
    assign up_hit       = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = btb_cnt[up_idx];
        if (bus.i_upd_taken) begin
            if (cnt_next != 2'b11) cnt_next = cnt_next + 2'b01;
        end else if (cnt_next != 2'b00) begin
            cnt_next = cnt_next - 2'b01;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid[i] <= 1'b0;
                btb_cnt[i]   <= CNT_INIT;
            end
        end else begin
            if (bus.i_redirect)       pc_q <= bus.i_redirect_pc & 32'hFFFF_FFFC;
            else if (bus.i_pc_enable) pc_q <= pred_target;

            if (bus.i_upd_valid) begin
                if (up_hit) begin
                    btb_cnt[up_idx] <= cnt_next;
                end else if (bus.i_upd_taken) begin
                    btb_valid[up_idx] <= 1'b1;
                    btb_cnt[up_idx]   <= 2'b10;
                end
            end
        end
    end

    // NOTE: tag/target arrays are not reset; valid=0 masks them, keeping them plain RAM.
    always_ff @(posedge i_clk) begin
        if (!i_rst && bus.i_upd_valid && bus.i_upd_taken) begin
            btb_tag[up_idx]    <= up_tag;
            btb_target[up_idx] <= upd_tgt_word;
        end
    end

    assign bus.o_pc_cur      = pc_q;
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_pc_four     = pc_four;
    assign bus.o_instruct    = bus.i_imem_data;
    assign bus.o_prediction  = prediction;
    assign bus.o_pred_target = pred_target;
endmodule

// File: tb/tb_fetch_btb_stage.sv
// Bench for fetch_btb_stage: directed vector table from the test plan, then
// randomized traffic against a behavioural BTB model.
module tb_fetch_btb_stage;
    localparam int          DEPTH = 16;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [31:0] IMEM_KEY = 32'h1357_9BDF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_btb_stage_if bus ();

    fetch_btb_stage #(
        .BTB_DEPTH (DEPTH),
        .RESET_PC  (RPC),
        .CNT_INIT  (2'b01)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign bus.i_imem_data = ~bus.o_imem_addr ^ IMEM_KEY;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] pc,
                                 input logic pred, input logic [31:0] tgt);
        check({tag, " pc"},    bus.o_pc_cur, pc);
        check({tag, " four"},  bus.o_pc_four, pc + 32'd4);
        check({tag, " imem"},  bus.o_imem_addr, pc);
        check({tag, " instr"}, bus.o_instruct, ~pc ^ IMEM_KEY);
        check({tag, " pred"},  {31'd0, bus.o_prediction}, {31'd0, pred});
        check({tag, " tgt"},   bus.o_pred_target, tgt);
    endtask

    task automatic drive(input logic r, input logic en, input logic rd, input logic [31:0] rpc,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt);
        rst               = r;
        bus.i_pc_enable   = en;
        bus.i_redirect    = rd;
        bus.i_redirect_pc = rpc;
        bus.i_upd_valid   = uv;
        bus.i_upd_pc      = upc;
        bus.i_upd_taken   = ut;
        bus.i_upd_target  = utgt;
    endtask

    // Directed vectors: inputs applied in a cycle, expected outputs of that cycle.
    typedef struct {
        logic        rst, en, rd;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] exp_pc;
        logic        exp_pred;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic en, logic rd, logic [31:0] rpc,
                                logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                                logic [31:0] epc, logic epred, logic [31:0] etgt);
        vec_t v;
        v.rst = r; v.en = en; v.rd = rd; v.rpc = rpc;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.exp_pc = epc; v.exp_pred = epred; v.exp_tgt = etgt;
        return v;
    endfunction

    // Behavioural model: each entry remembers the word-aligned PC that owns it.
    logic [31:0] m_pc;
    bit          m_valid [DEPTH];
    logic [31:0] m_owner [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_cnt   [DEPTH];

    function automatic int m_index(logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit m_hit(logic [31:0] a);
        int k = m_index(a);
        return m_valid[k] && (m_owner[k] / (4 * DEPTH) == a / (4 * DEPTH));
    endfunction

    function automatic bit m_pred(logic [31:0] a);
        return m_hit(a) && (m_cnt[m_index(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(logic [31:0] a);
        return m_pred(a) ? m_tgt[m_index(a)] : a + 32'd4;
    endfunction

    task automatic m_step(input logic r, input logic en, input logic rd, input logic [31:0] rpc,
                          input logic uv, input logic [31:0] upc, input logic ut,
                          input logic [31:0] utgt);
        logic [31:0] nxt;
        int k;
        if (r) begin
            m_pc = RPC;
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = 1;
            end
            return;
        end
        nxt = rd ? (rpc & ~32'd3) : (en ? m_next(m_pc) : m_pc);
        if (uv) begin
            k = m_index(upc);
            if (m_hit(upc)) begin
                if (ut) begin
                    m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
                    m_tgt[k] = utgt & ~32'd3;
                end else begin
                    m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
                end
            end else if (ut) begin
                m_valid[k] = 1'b1;
                m_owner[k] = upc & ~32'd3;
                m_tgt[k]   = utgt & ~32'd3;
                m_cnt[k]   = 2;
            end
        end
        m_pc = nxt;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        //              rst en rd  rpc           uv upc           ut utgt         exp_pc        pr exp_tgt
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h108,      1, 32'h200,    32'h100,      0, 32'h104));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,      32'h104,      0, 32'h108));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,      32'h108,      1, 32'h200));
        vecs.push_back(mk(0, 0, 1, 32'h10B,       1, 32'h108,      1, 32'h200,    32'h200,      0, 32'h204));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h108,      1, 32'h200,    32'h108,      1, 32'h200));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h108,      1, 32'h200,    32'h108,      1, 32'h200));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h108,      1, 32'h200,    32'h108,      1, 32'h200));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h108,      0, 32'h0,      32'h108,      1, 32'h200));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h108,      0, 32'h0,      32'h108,      1, 32'h200));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h148,      1, 32'h400,    32'h108,      0, 32'h10C));
        vecs.push_back(mk(0, 0, 1, 32'h148,       0, 32'h0,        0, 32'h0,      32'h108,      0, 32'h10C));
        vecs.push_back(mk(0, 0, 1, 32'h303,       0, 32'h0,        0, 32'h0,      32'h148,      1, 32'h400));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h300,      0, 32'h0,      32'h300,      0, 32'h304));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,      32'h300,      0, 32'h304));
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0,      32'h304,      0, 32'h308));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,        0, 32'h0,      32'hFFFF_FFFC,0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h148,       0, 32'h0,        0, 32'h0,      32'h0,        0, 32'h4));
        vecs.push_back(mk(1, 1, 1, 32'h500,       1, 32'h100,      1, 32'h500,    32'h148,      1, 32'h400));
        vecs.push_back(mk(0, 0, 1, 32'h148,       0, 32'h0,        0, 32'h0,      32'h100,      0, 32'h104));
        vecs.push_back(mk(0, 0, 1, 32'h100,       0, 32'h0,        0, 32'h0,      32'h148,      0, 32'h14C));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,      32'h100,      0, 32'h104));

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].en, vecs[n].rd, vecs[n].rpc,
                  vecs[n].uv, vecs[n].upc, vecs[n].ut, vecs[n].utgt);
            #1;
            check_outputs($sformatf("vec%0d", n), vecs[n].exp_pc, vecs[n].exp_pred, vecs[n].exp_tgt);
            @(posedge clk);
            #1;
        end

        // Randomized traffic; a reset first aligns the model with the DUT.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        m_step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 800; c++) begin
            logic        r, en, rd, uv, ut;
            logic [31:0] rpc, upc, utgt;
            r    = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 3) != 0);
            rd   = ($urandom_range(0, 5) == 0);
            rpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 3))
                                                : 32'h2000 + 32'($urandom_range(0, 191));
            uv   = ($urandom_range(0, 1) == 1);
            upc  = ($urandom_range(0, 1) == 1) ? m_pc : 32'h2000 + 32'($urandom_range(0, 47)) * 4;
            ut   = ($urandom_range(0, 2) != 0);
            utgt = 32'h2000 + 32'($urandom_range(0, 255));
            drive(r, en, rd, rpc, uv, upc, ut, utgt);
            #1;
            check_outputs($sformatf("rnd%0d", c), m_pc, m_pred(m_pc), m_next(m_pc));
            @(posedge clk);
            m_step(r, en, rd, rpc, uv, upc, ut, utgt);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_btb_stage.md
# fetch_btb_stage

Parametrised instruction-fetch stage with a direct-mapped branch target buffer (BTB) and per-entry 2-bit saturating direction counters, replacing the single global predictor. It holds the PC, presents it to the instruction memory, and predicts the next PC (taken target or PC+4) every cycle. It accepts resolution updates and mispredict redirects from the execute stage, and feeds the IF/ID pipeline register.

## Interface
Parameters:
- BTB_DEPTH, 16, number of BTB entries; power of two, ≥2; IDX_W = log2(BTB_DEPTH)
- RESET_PC, 32'h0000_0000, PC value after reset; word aligned
- CNT_INIT, 2'b01, counter value written to every entry at reset (weakly not-taken)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_pc_enable  in  1  1 = PC may advance; 0 = stall, PC holds
- i_redirect  in  1  mispredict recovery from EX; overrides the prediction and the stall
- i_redirect_pc  in  32  correct next PC; bits [1:0] ignored and treated as 0
- i_upd_valid  in  1  a resolved branch/jump is presented this cycle
- i_upd_pc  in  32  PC of the resolved instruction
- i_upd_taken  in  1  actual direction
- i_upd_target  in  32  actual target; bits [1:0] treated as 0
- o_imem_addr  out  32  instruction memory byte address, equal to o_pc_cur
- i_imem_data  in  32  combinational read data from instruction memory
- o_pc_cur  out  32  current PC
- o_pc_four  out  32  o_pc_cur + 4, modulo 2^32
- o_instruct  out  32  i_imem_data passed through
- o_prediction  out  1  1 = current PC predicted taken
- o_pred_target  out  32  predicted next PC

## Operation
- Storage per entry: valid (1), tag (30−IDX_W, PC[31:IDX_W+2]), target (30, PC[31:2]), counter (2).
- Lookup, combinational on o_pc_cur: idx = pc[IDX_W+1:2]. hit = valid[idx] & tag match. o_prediction = hit & counter[idx][1]. o_pred_target = o_prediction ? {target,2'b00} : o_pc_four.
- PC next-state priority:
  1. i_rst → RESET_PC
  2. i_redirect → {i_redirect_pc[31:2],2'b00}, regardless of i_pc_enable
  3. i_pc_enable → o_pred_target
  4. otherwise hold
- Update, when i_upd_valid, at index/tag of i_upd_pc:
  - Entry hit, taken: counter +1, saturating at 3; target ← i_upd_target.
  - Entry hit, not taken: counter −1, saturating at 0; target unchanged.
  - Entry miss, taken: allocate. Set valid=1, write tag and target, counter=2'b10, replacing any previous occupant.
  - Entry miss, not taken: no change.
- Updates are independent of i_pc_enable and i_redirect.
- Counter arithmetic is 2-bit saturating, with no wrap: 3+1=3 and 0−1=0.
- PC wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (synchronous): PC=RESET_PC, all valid=0, all counters=CNT_INIT. Targets and tags are don't-care.
- Outputs in the cycle after reset: o_pc_cur=RESET_PC, o_pc_four=RESET_PC+4, o_prediction=0, o_pred_target=RESET_PC+4.
- Reset asserted mid-operation clears the BTB and PC on that edge. Any concurrent update or redirect is discarded.
- Lookup is zero-latency, combinational from the PC register.
- A new PC is visible one cycle after the controlling edge.
- BTB writes become visible on the edge after i_upd_valid.
- Same-cycle lookup and update to the same index: the lookup uses the pre-update contents.
- Redirect and update in the same cycle are both performed.
- A redirect during a stall still loads the redirect PC on that edge. The PC then holds there while i_pc_enable=0.

## Test plan
- Reset with RESET_PC=32'h100 → o_pc_cur=0x100, 0x104, 0x108 on successive enabled cycles; o_prediction=0 throughout.
- Update {pc=0x108, taken, target=0x200} → next time o_pc_cur=0x108: o_prediction=1, o_pred_target=0x200, following PC=0x200.
- Saturation: four taken updates, then one not-taken at 0x108 → still predicted taken (3→2). A second not-taken (2→1) → o_pred_target=0x10C.
- Aliasing, BTB_DEPTH=16: allocate 0x108, then a taken update at 0x148 (same idx, different tag) → 0x108 now misses and predicts 0x10C; 0x148 hits.
- i_pc_enable=0 with i_redirect=1, i_redirect_pc=0x303 → o_pc_cur=0x300 next cycle and holds while stalled. Not-taken update on an empty entry → no allocation (0x300 sequence unchanged).
- PC=0xFFFF_FFFC, enabled, miss → o_pc_four=0, next o_pc_cur=0. Assert i_rst mid-run after allocations → all lookups miss.
